// File: rtl/irrigation_zone_scheduler_pkg.sv
// irrigation_zone_scheduler_pkg: shared state encoding and default sizing for the zone scheduler
package irrigation_zone_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_OPEN, S_WATER, S_DRAIN, S_FAULT} state_t;
  localparam int SETTLE_DEF = 2;
  localparam int ZONE_DUR_W = 8;
endpackage

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// irrigation_zone_scheduler_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module irrigation_zone_scheduler_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        gnt = N'(1) << ((int'(ptr) + i) % N);
        idx = IW'((int'(ptr) + i) % N);
      end
  end
endmodule

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: shares one pump among valve zones with settle, water, drain and fault handling
module irrigation_zone_scheduler
  import irrigation_zone_scheduler_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter int DUR_W = ZONE_DUR_W,
  parameter int SETTLE = SETTLE_DEF,
  parameter int IDX_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_ZONES-1:0]       zone_req,
  input  logic [N_ZONES*DUR_W-1:0] zone_dur,
  input  logic [N_ZONES-1:0]       moisture_ok,
  input  logic                     pump_fault,
  output logic                     pump_on,
  output logic [N_ZONES-1:0]       valve_open,
  output logic                     busy,
  output logic [IDX_W-1:0]         active_zone,
  output logic [DUR_W-1:0]         remaining,
  output logic [N_ZONES-1:0]       zone_done,
  output logic [N_ZONES-1:0]       zone_skip,
  output logic                     fault
);
  localparam int CW = DUR_W > $clog2(SETTLE + 1) ? DUR_W : $clog2(SETTLE + 1);
  state_t state;
  logic [IDX_W-1:0] grant, ptr, arb_idx, fin_idx;
  logic [N_ZONES-1:0] pending, arb_gnt, grant_oh, fin_oh;
  logic [CW-1:0] cnt;
  logic [DUR_W-1:0] dur_q, sel_dur;
  logic skip_now, done_now, in_service, wet_end;
  irrigation_zone_scheduler_rr_arbiter #(.N(N_ZONES), .IW(IDX_W)) u_arb (
    .req(pending),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  always_comb begin
    sel_dur = zone_dur[int'(arb_idx)*DUR_W +: DUR_W];
    grant_oh = N_ZONES'(1) << grant;
    skip_now = state == S_SELECT && !pump_fault && (sel_dur == '0 || moisture_ok[arb_idx]);
    done_now = state == S_DRAIN && cnt == '0 && !pump_fault;
    fin_idx = skip_now ? arb_idx : grant;
    fin_oh = skip_now ? arb_gnt : done_now ? grant_oh : '0;
    wet_end = moisture_ok[grant] || cnt == CW'(1);
    in_service = state inside {S_OPEN, S_WATER, S_DRAIN};
    pump_on = state == S_WATER;
    valve_open = in_service ? grant_oh : '0;
    busy = state != S_IDLE;
    fault = state == S_FAULT;
    active_zone = state == S_IDLE ? '0 : state == S_SELECT ? arb_idx : grant;
    remaining = state == S_WATER ? cnt[DUR_W-1:0] : '0;
    zone_done = done_now ? grant_oh : '0;
    zone_skip = skip_now ? arb_gnt : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      pending <= '0;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
      dur_q <= '0;
    end else begin
      pending <= (pending & ~fin_oh) | zone_req;
      if (|fin_oh) ptr <= fin_idx == IDX_W'(N_ZONES - 1) ? '0 : fin_idx + IDX_W'(1);
      if (state == S_SELECT) begin
        grant <= arb_idx;
        dur_q <= sel_dur;
      end
      if (pump_fault && (state != S_IDLE || |pending)) state <= S_FAULT;
      else case (state)
        S_IDLE: if (enable && |pending) state <= S_SELECT;
        S_SELECT: begin
          cnt <= CW'(SETTLE - 1);
          state <= skip_now ? S_IDLE : S_OPEN;
        end
        S_OPEN: begin
          cnt <= cnt == '0 ? CW'(dur_q) : cnt - CW'(1);
          if (cnt == '0) state <= S_WATER;
        end
        S_WATER: begin
          cnt <= wet_end ? CW'(SETTLE - 1) : cnt - CW'(1);
          if (wet_end) state <= S_DRAIN;
        end
        S_DRAIN: if (cnt == '0) state <= S_IDLE; else cnt <= cnt - CW'(1);
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler: directed and random stimulus checked every cycle against a timeline model
module tb_irrigation_zone_scheduler;
  localparam int N = 4, DW = 8, SETTLE = 2;
  localparam int M_IDLE = 0, M_SEL = 1, M_SVC = 2, M_FLT = 3;
  logic clk = 0, reset = 1, enable = 1, pump_fault = 0;
  logic [N-1:0] zone_req = '0, moisture_ok = '0;
  logic [N*DW-1:0] zone_dur = '0;
  logic pump_on, busy, fault;
  logic [N-1:0] valve_open, zone_done, zone_skip;
  logic [1:0] active_zone;
  logic [DW-1:0] remaining;
  int checks = 0, errors = 0;
  int mode = M_IDLE, t = 0, water_end = 0, mgrant = 0, mdur = 0, mptr = 0, g = 0, e_rem = 0, e_active = 0;
  logic [N-1:0] mpend = '0, old_pend, e_valve, e_done, e_skip;
  logic water;
  int c_valve, c_pump, c_done, c_skip, c_fault, c_busy, c_multi, rise_rem, prev_pump, last_rem, last_pump_rem;
  int last_pump, last_valve, last_fault, last_busy, ord_code, pf_left = 0, z;
  irrigation_zone_scheduler #(.N_ZONES(N), .DUR_W(DW), .SETTLE(SETTLE), .IDX_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .zone_req(zone_req),
    .zone_dur(zone_dur),
    .moisture_ok(moisture_ok),
    .pump_fault(pump_fault),
    .pump_on(pump_on),
    .valve_open(valve_open),
    .busy(busy),
    .active_zone(active_zone),
    .remaining(remaining),
    .zone_done(zone_done),
    .zone_skip(zone_skip),
    .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic int first_pend();
    for (int i = 0; i < N; i++)
      if (mpend[(mptr + i) % N]) return (mptr + i) % N;
    return 0;
  endfunction
  function automatic int dur_of(input int zz);
    return int'(zone_dur[zz*DW +: DW]);
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      mode = M_IDLE;
      mpend = '0;
      mptr = 0;
      mgrant = 0;
      chk("rst_pump", pump_on, 0);
      chk("rst_valve", valve_open, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      chk("rst_active", active_zone, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_done", zone_done, 0);
      chk("rst_skip", zone_skip, 0);
    end else begin
      g = first_pend();
      water = mode == M_SVC && t >= SETTLE && t < water_end;
      e_valve = mode == M_SVC ? N'(1) << mgrant : '0;
      e_rem = water ? mdur - (t - SETTLE) : 0;
      e_skip = (mode == M_SEL && !pump_fault && (dur_of(g) == 0 || moisture_ok[g])) ? N'(1) << g : '0;
      e_done = (mode == M_SVC && t == water_end + SETTLE - 1 && !pump_fault) ? N'(1) << mgrant : '0;
      e_active = mode == M_IDLE ? 0 : mode == M_SEL ? g : mgrant;
      chk("pump_on", pump_on, water);
      chk("valve_open", valve_open, e_valve);
      chk("busy", busy, mode != M_IDLE);
      chk("fault", fault, mode == M_FLT);
      chk("active_zone", active_zone, e_active);
      chk("remaining", remaining, e_rem);
      chk("zone_done", zone_done, e_done);
      chk("zone_skip", zone_skip, e_skip);
      old_pend = mpend;
      mpend = (mpend & ~(e_skip | e_done)) | zone_req;
      if (e_skip != 0) mptr = (g + 1) % N;
      if (e_done != 0) mptr = (mgrant + 1) % N;
      if (mode == M_SEL) mgrant = g;
      if (pump_fault && (mode != M_IDLE || old_pend != 0)) mode = M_FLT;
      else if (mode == M_IDLE) mode = (enable && old_pend != 0) ? M_SEL : M_IDLE;
      else if (mode == M_SEL) begin
        if (e_skip != 0) mode = M_IDLE;
        else begin
          mode = M_SVC;
          mdur = dur_of(g);
          t = 0;
          water_end = SETTLE + mdur;
        end
      end else if (mode == M_SVC) begin
        if (water && moisture_ok[mgrant]) water_end = t + 1;
        if (e_done != 0) mode = M_IDLE;
        else t++;
      end else mode = M_IDLE;
    end
  end
  task automatic clr_stats();
    c_valve = 0; c_pump = 0; c_done = 0; c_skip = 0; c_fault = 0; c_busy = 0; c_multi = 0;
    rise_rem = -1; prev_pump = 0; last_pump_rem = -1; ord_code = 0;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      #2;
      c_valve += int'(valve_open != 0);
      c_pump += int'(pump_on);
      c_done += $countones(zone_done);
      c_skip += $countones(zone_skip);
      c_fault += int'(fault);
      c_busy += int'(busy);
      if ($countones(valve_open) > 1 || (pump_on && $countones(valve_open) != 1)) c_multi++;
      if (pump_on && prev_pump == 0) rise_rem = remaining;
      if (pump_on) last_pump_rem = remaining;
      if (zone_done != 0) ord_code = ord_code * 10 + int'(active_zone) + 1;
      prev_pump = pump_on;
      last_rem = remaining;
      last_pump = pump_on;
      last_valve = valve_open;
      last_fault = fault;
      last_busy = busy;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1;
    zone_req = '0;
    moisture_ok = '0;
    pump_fault = 0;
    enable = 1;
    @(posedge clk);
    #1 reset = 0;
  endtask
  initial begin
    zone_dur = {4{8'd3}};
    repeat (2) @(posedge clk);
    #1 reset = 0;
    clr_stats();
    run(2);
    chk("reset_busy", last_busy, 0);
    zone_dur = {8'd3, 8'd3, 8'd5, 8'd3};
    clr_stats();
    zone_req = 4'b0010; run(1); zone_req = '0; run(13);
    chk("t1_valve_cycles", c_valve, 9);
    chk("t1_pump_cycles", c_pump, 5);
    chk("t1_first_rem", rise_rem, 5);
    chk("t1_last_rem", last_pump_rem, 1);
    chk("t1_done", c_done, 1);
    chk("t1_busy_end", last_busy, 0);
    do_reset();
    zone_dur = {4{8'd3}};
    clr_stats();
    zone_req = 4'b1011; run(1); zone_req = '0; run(22);
    zone_req = 4'b0001; run(1); zone_req = '0; run(30);
    chk("t2_order", ord_code, 1241);
    chk("t2_multi_valve", c_multi, 0);
    zone_dur = {8'd3, 8'd0, 8'd3, 8'd3};
    moisture_ok = 4'b1000;
    clr_stats();
    zone_req = 4'b1100; run(1); zone_req = '0; run(10);
    chk("t3_skips", c_skip, 2);
    chk("t3_pump", c_pump, 0);
    chk("t3_valve", c_valve, 0);
    moisture_ok = '0;
    zone_dur = {8'd3, 8'd3, 8'd3, 8'd10};
    clr_stats();
    zone_req = 4'b0001; run(1); zone_req = '0; run(7);
    moisture_ok = 4'b0001; run(1);
    chk("t4_rem_at_wet", last_rem, 7);
    chk("t4_pump_at_wet", last_pump, 1);
    run(6);
    moisture_ok = '0;
    chk("t4_pump_cycles", c_pump, 4);
    chk("t4_valve_cycles", c_valve, 8);
    chk("t4_done", c_done, 1);
    zone_dur = {8'd3, 8'd3, 8'd5, 8'd3};
    clr_stats();
    zone_req = 4'b0010; run(1); zone_req = '0; run(5);
    pump_fault = 1; run(2);
    chk("t5_fault_pump", last_pump, 0);
    chk("t5_fault_valve", last_valve, 0);
    chk("t5_fault_flag", last_fault, 1);
    run(1);
    pump_fault = 0; run(16);
    chk("t5_pump_cycles", c_pump, 7);
    chk("t5_fault_cycles", c_fault, 3);
    chk("t5_restart_rem", rise_rem, 5);
    chk("t5_done", c_done, 1);
    clr_stats();
    enable = 0;
    zone_req = 4'b0100; run(1); zone_req = '0; run(6);
    chk("t6_disabled_busy", c_busy, 0);
    enable = 1;
    run(4);
    chk("t6_pump_before_reset", pump_on, 1);
    #1 reset = 1;
    #1;
    chk("t6_async_pump", pump_on, 0);
    chk("t6_async_valve", valve_open, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_remaining", remaining, 0);
    @(posedge clk);
    #1 reset = 0;
    clr_stats();
    run(6);
    chk("t6_pending_cleared", c_busy, 0);
    repeat (3000) begin
      enable = $urandom_range(0, 7) != 0;
      zone_req = $urandom_range(0, 5) == 0 ? N'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) begin
        z = $urandom_range(0, N - 1);
        zone_dur[z*DW +: DW] = DW'($urandom_range(0, 9));
      end
      moisture_ok = $urandom_range(0, 19) == 0 ? N'($urandom) : '0;
      if (pf_left > 0) pf_left--;
      else if ($urandom_range(0, 149) == 0) pf_left = $urandom_range(1, 4);
      pump_fault = pf_left > 0;
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
      end
      run(1);
    end
    pump_fault = 0;
    zone_req = '0;
    moisture_ok = '0;
    run(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
